// File: rtl/serial_cmd_pkg.sv
// Shared opcode constants, response lengths and controller state type for the
// serial command initiator.
package serial_cmd_pkg;

    localparam logic [7:0] CMD_VERSION       = 8'd0;
    localparam logic [7:0] CMD_DEADTICKS     = 8'd1;
    localparam logic [7:0] CMD_FIRINGTICKS   = 8'd2;
    localparam logic [7:0] CMD_TOGGLE_OUT    = 8'd3;
    localparam logic [7:0] CMD_TOGGLE_CLKSRC = 8'd4;
    localparam logic [7:0] CMD_SET_PHASE     = 8'd5;
    localparam logic [7:0] CMD_MASK1         = 8'd6;
    localparam logic [7:0] CMD_MASK2         = 8'd7;
    localparam logic [7:0] CMD_PASSTHRU      = 8'd8;
    localparam logic [7:0] CMD_HISTO         = 8'd10;
    localparam logic [7:0] CMD_VETOLAST      = 8'd11;
    localparam logic [7:0] CMD_PLL_RESET     = 8'd13;
    localparam logic [7:0] CMD_VETO_CYCLES   = 8'd14;
    localparam logic [7:0] CMD_CLK_AS_INPUT  = 8'd15;

    localparam logic [7:0] VERSION_LEN = 8'd1;
    localparam logic [7:0] HISTO_LEN   = 8'd136;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_OP,
        ST_GAP,
        ST_SEND_ARG,
        ST_POST,
        ST_WAIT_RESP,
        ST_DONE
    } state_e;

    // Where the controller goes once the final command byte has been presented.
    function automatic state_e after_last_byte(input logic [7:0] resp_len);
        return (resp_len != 8'd0) ? ST_WAIT_RESP : ST_POST;
    endfunction

endpackage

// File: rtl/serial_tx_pacer.sv
// Emulated UART transmitter pacing: accepts processor bytes, holds tx_busy for
// BUSY_CYCLES per accepted byte and flags starts that arrive while busy.
module serial_tx_pacer #(
    parameter int BUSY_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tx_start,
    output logic tx_busy,
    output logic capture,
    output logic proto_err
);

    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

    logic [CW-1:0] hold_cnt;

    assign capture   = tx_start && !tx_busy;
    assign proto_err = tx_start && tx_busy;

    // A start during busy never reloads the count, so the processor sees a fixed hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy  <= 1'b0;
            hold_cnt <= '0;
        end else if (capture) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            tx_busy  <= 1'b1;
            hold_cnt <= CW'(BUSY_CYCLES - 1);
        end else if (tx_busy) begin
            if (hold_cnt == '0) begin
                tx_busy <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_cmd_initiator.sv
// Command master for the serial command processor: sends opcode/argument bytes
// with the required pacing and collects the response bytes.
// Optional little-endian word assembly: define SERIAL_CMD_INITIATOR_WORD_ASM_EN.
module serial_cmd_initiator
    import serial_cmd_pkg::*;
#(
    parameter int INTER_BYTE_GAP = 4,
    parameter int POST_GAP       = 4,
    parameter int BUSY_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_opcode,
    input  logic [7:0]  req_arg,
    input  logic        req_has_arg,
    input  logic [7:0]  req_resp_len,
    output logic        rx_ready,
    output logic [7:0]  rx_data,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic [7:0]  resp_index,
    output logic        resp_last,
    output logic        done,
    output logic        timeout,
    output logic        stray_err,
    output logic        word_valid,
    output logic [31:0] word_data,
    output logic [5:0]  word_index
);

    state_e      state, state_d;
    logic [7:0]  arg_q;
    logic [7:0]  len_q;
    logic        has_arg_q;
    logic [7:0]  resp_cnt;
    logic [15:0] pace_cnt;
    logic [31:0] to_cnt;
    logic        capture;
    logic        proto_err;
    logic        accept;
    logic        resp_cap;
    logic        to_hit;

    serial_tx_pacer #(
        .BUSY_CYCLES (BUSY_CYCLES)
    ) u_pacer (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .capture   (capture),
        .proto_err (proto_err)
    );

    assign accept   = req_valid && req_ready;
    // Only the first resp_len bytes of a response are delivered; anything else is stray.
    assign resp_cap = capture && (state == ST_WAIT_RESP) && (resp_cnt < len_q);
    assign to_hit   = (state == ST_WAIT_RESP) && !capture &&
                      (to_cnt >= 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        unique case (state)
            ST_IDLE:      if (accept) state_d = ST_SEND_OP;
            ST_SEND_OP:   state_d = has_arg_q ? ST_GAP : after_last_byte(len_q);
            ST_GAP:       if (pace_cnt == 16'(INTER_BYTE_GAP - 1)) state_d = ST_SEND_ARG;
            ST_SEND_ARG:  state_d = after_last_byte(len_q);
            ST_POST:      if (pace_cnt == 16'(POST_GAP - 1)) state_d = ST_DONE;
            ST_WAIT_RESP: if (to_hit || ((resp_cnt == len_q) && !tx_busy)) state_d = ST_DONE;
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            arg_q     <= '0;
            len_q     <= '0;
            has_arg_q <= 1'b0;
            resp_cnt  <= '0;
            pace_cnt  <= '0;
            to_cnt    <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                arg_q     <= req_arg;
                len_q     <= req_resp_len;
                has_arg_q <= req_has_arg;
            end
            if (accept) begin
                resp_cnt <= '0;
            end else if (resp_cap) begin
                resp_cnt <= resp_cnt + 8'd1;
            end
            // Gap and post counters restart on every state change.
            if (state_d != state) begin
                pace_cnt <= '0;
            end else if (state == ST_GAP || state == ST_POST) begin
                pace_cnt <= pace_cnt + 16'd1;
            end
            if (state != ST_WAIT_RESP || capture) begin
                to_cnt <= '0;
            end else if (to_cnt != '1) begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

    // Every output is a flop loaded from the next-state decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            rx_ready   <= 1'b0;
            rx_data    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_index <= '0;
            resp_last  <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            stray_err  <= 1'b0;
        end else begin
            req_ready  <= (state_d == ST_IDLE);
            rx_ready   <= (state_d == ST_SEND_OP) || (state_d == ST_SEND_ARG);
            if (accept) begin
                rx_data <= req_opcode;
            end else if (state_d == ST_SEND_ARG) begin
                rx_data <= arg_q;
            end
            resp_valid <= resp_cap;
            resp_last  <= resp_cap && (resp_cnt == len_q - 8'd1);
            if (resp_cap) begin
                resp_data  <= tx_data;
                resp_index <= resp_cnt;
            end
            done    <= (state_d == ST_DONE);
            timeout <= to_hit;
            // A fresh error in the accept cycle outranks the clear.
            if (proto_err || (capture && !resp_cap)) begin
                stray_err <= 1'b1;
            end else if (accept) begin
                stray_err <= 1'b0;
            end
        end
    end

`ifdef SERIAL_CMD_INITIATOR_WORD_ASM_EN
    logic [23:0] word_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf   <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_index <= '0;
        end else begin
            word_valid <= 1'b0;
            if (state == ST_DONE) begin
                word_buf <= '0;
            end else if (resp_valid) begin
                unique case (resp_index[1:0])
                    2'd0: word_buf[7:0]   <= resp_data;
                    2'd1: word_buf[15:8]  <= resp_data;
                    2'd2: word_buf[23:16] <= resp_data;
                    default: begin
                        word_data  <= {resp_data, word_buf};
                        word_valid <= 1'b1;
                        word_index <= resp_index[7:2];
                    end
                endcase
            end
        end
    end
`else
    assign word_valid = 1'b0;
    assign word_data  = '0;
    assign word_index = '0;
`endif

endmodule

// File: tb/tb_serial_cmd_initiator.sv
// Self-checking bench for serial_cmd_initiator: a processor stub answers commands
// and a monitor records every output event for comparison with expected values.
module tb_serial_cmd_initiator;
    import serial_cmd_pkg::*;

    localparam int GAP  = 4;
    localparam int POST = 4;
    localparam int BUSY = 4;
    localparam int TMO  = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_has_arg;
    logic [7:0]  req_opcode, req_arg, req_resp_len;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_start, tx_busy;
    logic [7:0]  tx_data;
    logic        resp_valid, resp_last, done, timeout, stray_err, word_valid;
    logic [7:0]  resp_data, resp_index;
    logic [31:0] word_data;
    logic [5:0]  word_index;

    always #5 clk = ~clk;

    serial_cmd_initiator #(
        .INTER_BYTE_GAP (GAP),
        .POST_GAP       (POST),
        .BUSY_CYCLES    (BUSY),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_arg      (req_arg),
        .req_has_arg  (req_has_arg),
        .req_resp_len (req_resp_len),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_index   (resp_index),
        .resp_last    (resp_last),
        .done         (done),
        .timeout      (timeout),
        .stray_err    (stray_err),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .word_index   (word_index)
    );

    typedef struct { int cyc; logic [7:0] d; } rx_ev_t;
    typedef struct { int cyc; logic [7:0] d; logic [7:0] idx; logic last; } resp_ev_t;
    typedef struct { int cyc; logic to; } done_ev_t;
    typedef struct { logic [31:0] d; logic [5:0] idx; } word_ev_t;

    rx_ev_t   rx_q[$];
    resp_ev_t resp_q[$];
    done_ev_t done_q[$];
    word_ev_t word_q[$];
    int       busy_runs[$];
    int       ncyc = 0;
    int       busy_run = 0;
    int       checks = 0;
    int       errors = 0;

    // Event recorder, sampling half a cycle away from the active edge.
    initial forever begin
        @(negedge clk);
        ncyc++;
        if (rx_ready)   rx_q.push_back('{ncyc, rx_data});
        if (resp_valid) resp_q.push_back('{ncyc, resp_data, resp_index, resp_last});
        if (done)       done_q.push_back('{ncyc, timeout});
        if (word_valid) word_q.push_back('{word_data, word_index});
        if (tx_busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rx_q.delete();
        resp_q.delete();
        done_q.delete();
        word_q.delete();
        busy_runs.delete();
        busy_run = 0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] arg,
                         input logic has_arg, input logic [7:0] len);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_wait: got %b exp 1", req_ready);
        end
        req_valid    = 1'b1;
        req_opcode   = op;
        req_arg      = arg;
        req_has_arg  = has_arg;
        req_resp_len = len;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int dly);
        int n = 0;
        repeat (dly) tick();
        while (tx_busy && n < 50) begin
            tick();
            n++;
        end
        tx_start = 1'b1;
        tx_data  = d;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic wait_rx(input int cnt);
        int n = 0;
        while (rx_q.size() < cnt && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Full transaction with a stub that answers after the last command byte.
    task automatic run_cmd(input string name, input logic [7:0] op, input logic [7:0] arg,
                           input logic has_arg, input logic [7:0] len,
                           input logic [7:0] bytes[$], input bit inject);
        int exp_rx;
        int exp_done;
        int exp_words;
        int bad;
        logic [31:0] exp_w;
        exp_rx = has_arg ? 2 : 1;
        clear_q();
        issue(op, arg, has_arg, len);
        checks++;
        if (stray_err !== 1'b0) begin
            errors++;
            $display("FAIL %s stray_clear: got %b exp 0", name, stray_err);
        end
        wait_rx(exp_rx);
        foreach (bytes[i]) begin
            send_byte(bytes[i], int'($urandom_range(0, 3)));
            if (inject && i == 0) begin
                tx_start = 1'b1;
                tx_data  = ~bytes[i];
                tick();
                tx_start = 1'b0;
            end
        end
        wait_done(TMO + 60);

        checks++;
        if (rx_q.size() != exp_rx) begin
            errors++;
            $display("FAIL %s rx_count: got %0d exp %0d", name, rx_q.size(), exp_rx);
        end else begin
            checks++;
            if (rx_q[0].d !== op) begin
                errors++;
                $display("FAIL %s rx_opcode: got %h exp %h", name, rx_q[0].d, op);
            end
            if (has_arg) begin
                checks++;
                if (rx_q[1].d !== arg || rx_q[1].cyc - rx_q[0].cyc != GAP + 1) begin
                    errors++;
                    $display("FAIL %s rx_arg: got %h after %0d exp %h after %0d", name,
                             rx_q[1].d, rx_q[1].cyc - rx_q[0].cyc, arg, GAP + 1);
                end
            end
        end

        checks++;
        if (resp_q.size() != int'(len)) begin
            errors++;
            $display("FAIL %s resp_count: got %0d exp %0d", name, resp_q.size(), len);
        end else begin
            foreach (resp_q[i]) begin
                checks++;
                if (resp_q[i].d !== bytes[i] || resp_q[i].idx !== 8'(i) ||
                    resp_q[i].last !== (i == int'(len) - 1)) begin
                    errors++;
                    $display("FAIL %s resp[%0d]: got d=%h idx=%0d last=%b exp d=%h idx=%0d last=%b",
                             name, i, resp_q[i].d, resp_q[i].idx, resp_q[i].last,
                             bytes[i], i, (i == int'(len) - 1));
                end
            end
        end

        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d exp 1", name, done_q.size());
        end else if (rx_q.size() > 0) begin
            if (len != 0 && resp_q.size() > 0)
                exp_done = resp_q[resp_q.size() - 1].cyc + BUSY + 1;
            else
                exp_done = rx_q[rx_q.size() - 1].cyc + POST + 1;
            checks++;
            if (done_q[0].cyc != exp_done || done_q[0].to !== 1'b0) begin
                errors++;
                $display("FAIL %s done_timing: got cyc=%0d to=%b exp cyc=%0d to=0",
                         name, done_q[0].cyc, done_q[0].to, exp_done);
            end
        end

        checks++;
        if (req_ready !== 1'b1 || stray_err !== inject) begin
            errors++;
            $display("FAIL %s post_done: got ready=%b stray=%b exp ready=1 stray=%b",
                     name, req_ready, stray_err, inject);
        end

        bad = 0;
        foreach (busy_runs[i]) if (busy_runs[i] != BUSY) bad++;
        checks++;
        if (busy_runs.size() != int'(len) || bad != 0) begin
            errors++;
            $display("FAIL %s busy_runs: got %0d runs %0d wrong exp %0d runs of %0d",
                     name, busy_runs.size(), bad, len, BUSY);
        end

`ifdef SERIAL_CMD_INITIATOR_WORD_ASM_EN
        exp_words = int'(len) / 4;
`else
        exp_words = 0;
`endif
        checks++;
        if (word_q.size() != exp_words) begin
            errors++;
            $display("FAIL %s word_count: got %0d exp %0d", name, word_q.size(), exp_words);
        end else begin
            foreach (word_q[k]) begin
                exp_w = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
                checks++;
                if (word_q[k].d !== exp_w || word_q[k].idx !== 6'(k)) begin
                    errors++;
                    $display("FAIL %s word[%0d]: got %h idx %0d exp %h idx %0d",
                             name, k, word_q[k].d, word_q[k].idx, exp_w, k);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_ready, rx_ready, rx_data, tx_busy, resp_valid, resp_data, resp_index,
             resp_last, done, timeout, stray_err, word_valid, word_data, word_index} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs exp all 0");
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", req_ready);
        end
    endtask

    task automatic test_version();
        logic [7:0] q[$];
        q = {8'h17};
        run_cmd("version", CMD_VERSION, 8'h00, 1'b0, VERSION_LEN, q, 1'b0);
    endtask

    task automatic test_arg_cmd();
        logic [7:0] q[$];
        run_cmd("deadticks", CMD_DEADTICKS, 8'h20, 1'b1, 8'd0, q, 1'b0);
    endtask

    task automatic test_histogram();
        logic [7:0] q[$];
        for (int i = 0; i < int'(HISTO_LEN); i++) q.push_back(8'(i));
        run_cmd("histogram", CMD_HISTO, 8'h00, 1'b0, HISTO_LEN, q, 1'b0);
    endtask

    task automatic test_timeout();
        clear_q();
        issue(CMD_VERSION, 8'h00, 1'b0, 8'd1);
        wait_done(TMO + 60);
        checks++;
        if (done_q.size() != 1 || rx_q.size() != 1) begin
            errors++;
            $display("FAIL timeout_done: got %0d done %0d rx exp 1 1", done_q.size(), rx_q.size());
        end else begin
            checks++;
            if (done_q[0].to !== 1'b1 || done_q[0].cyc != rx_q[0].cyc + 1 + TMO) begin
                errors++;
                $display("FAIL timeout_timing: got cyc=%0d to=%b exp cyc=%0d to=1",
                         done_q[0].cyc, done_q[0].to, rx_q[0].cyc + 1 + TMO);
            end
        end
        checks++;
        if (resp_q.size() != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL timeout_idle: got resp=%0d ready=%b exp resp=0 ready=1",
                     resp_q.size(), req_ready);
        end
    endtask

    task automatic test_stray();
        logic [7:0] q[$];
        clear_q();
        tx_start = 1'b1;
        tx_data  = 8'h5A;
        tick();
        tx_data  = 8'hA5;
        tick();
        tx_start = 1'b0;
        repeat (6) tick();
        checks++;
        if (stray_err !== 1'b1 || resp_q.size() != 0) begin
            errors++;
            $display("FAIL stray_idle: got stray=%b resp=%0d exp stray=1 resp=0",
                     stray_err, resp_q.size());
        end
        checks++;
        if (busy_runs.size() != 1 || (busy_runs.size() == 1 && busy_runs[0] != BUSY)) begin
            errors++;
            $display("FAIL stray_busy: got %0d runs exp one run of %0d", busy_runs.size(), BUSY);
        end
        q = {8'h17};
        run_cmd("stray_clear", CMD_VERSION, 8'h00, 1'b0, VERSION_LEN, q, 1'b0);
        q = {8'h3C, 8'hC3};
        run_cmd("drop_busy", CMD_MASK1, 8'h00, 1'b0, 8'd2, q, 1'b1);
    endtask

    task automatic test_random();
        logic [7:0] ops[14];
        logic [7:0] q[$];
        logic [7:0] len;
        ops = '{CMD_VERSION, CMD_DEADTICKS, CMD_FIRINGTICKS, CMD_TOGGLE_OUT, CMD_TOGGLE_CLKSRC,
                CMD_SET_PHASE, CMD_MASK1, CMD_MASK2, CMD_PASSTHRU, CMD_HISTO, CMD_VETOLAST,
                CMD_PLL_RESET, CMD_VETO_CYCLES, CMD_CLK_AS_INPUT};
        for (int t = 0; t < 8; t++) begin
            q.delete();
            len = 8'($urandom_range(0, 9));
            for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
            run_cmd("random", ops[$urandom_range(0, 13)], 8'($urandom), 1'($urandom),
                    len, q, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$];
        clear_q();
        issue(CMD_HISTO, 8'h00, 1'b0, HISTO_LEN);
        wait_rx(1);
        for (int i = 0; i <= 50; i++) send_byte(8'(i), 0);
        tick();
        checks++;
        if (resp_q.size() != 51) begin
            errors++;
            $display("FAIL reset_mid_count: got %0d exp 51", resp_q.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rx_ready, rx_data, tx_busy, resp_valid, resp_data, resp_index,
             resp_last, done, timeout, stray_err, word_valid, word_data, word_index} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b idx=%0d exp all 0", tx_busy, resp_index);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_done: got %0d exp 0", done_q.size());
        end
        q = {8'h17};
        run_cmd("post_reset_version", CMD_VERSION, 8'h00, 1'b0, VERSION_LEN, q, 1'b0);
    endtask

    initial begin
        req_valid    = 1'b0;
        req_opcode   = '0;
        req_arg      = '0;
        req_has_arg  = 1'b0;
        req_resp_len = '0;
        tx_start     = 1'b0;
        tx_data      = '0;
        test_reset();
        test_version();
        test_arg_cmd();
        test_histogram();
        test_timeout();
        test_stray();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
